cjb_nbit_cntdn_v: RTL and testbench
===================================

CJB_NBIT_CNTDN_V -- requirements
Module: cjb_nbit_cntdn_v

Interface
REQ-001 Parameter: n, 8, width of count, reload value and d.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 d  input  n  reload value, captured on ld.
REQ-005 ld  input  1  load d into q and reload register rv; aborts any run.
REQ-006 start  input  1  begin countdown from rv; honoured only in IDLE.
REQ-007 cntdn  input  1  decrement enable; honoured only in RUN.
REQ-008 reload  input  1  auto-reload mode select, sampled at terminal count.
REQ-009 ack  input  1  acknowledge completion; honoured only in DONE.
REQ-010 q  output  n  current count, registered.
REQ-011 busy  output  1  high while state = RUN.
REQ-012 done  output  1  high while state = DONE.
REQ-013 tc  output  1  registered one-clock terminal-count pulse.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; busy and done SHALL be decoded from the registered state only.
REQ-015 Priority at each rising edge SHALL be: ld > start/ack > cntdn; reset overrides all asynchronously.
REQ-016 ld=1 (any state) SHALL set q<=d, rv<=d, state<=IDLE, tc<=0.
REQ-017 IDLE with start=1 and rv!=0 SHALL set q<=rv, state<=RUN, tc<=0.
REQ-018 IDLE with start=1 and rv=0 SHALL set q<=0, state<=DONE, tc<=1 (zero-length run).
REQ-019 RUN with cntdn=0 SHALL hold q and state; tc<=0.
REQ-020 RUN with cntdn=1 and q>1 SHALL set q<=q-1, tc<=0.
REQ-021 RUN with cntdn=1, q=1, reload=0 SHALL set q<=0, state<=DONE, tc<=1.
REQ-022 RUN with cntdn=1, q=1, reload=1 SHALL set q<=rv, state stays RUN, tc<=1; q never shows 0 in this case.
REQ-023 Decrement SHALL be modulo 2^n; q SHALL never wrap below 0 (RUN never holds q=0).
REQ-024 DONE SHALL hold q=0; ack=1 SHALL set state<=IDLE; start in DONE SHALL be ignored even with ack the same cycle.
REQ-025 start in RUN or DONE, cntdn outside RUN, ack outside DONE SHALL have no effect.
REQ-026 tc SHALL be high for exactly one clock per terminal count and 0 on every other edge.
REQ-027 Latency: q reflects any ld/start/decrement on the same edge; no combinational input-to-output paths.

Reset
REQ-028 reset=0 SHALL asynchronously set q=0, rv=0, tc=0, state=IDLE (busy=0, done=0), including mid-RUN.
REQ-029 After reset deasserts, the first active edge SHALL follow REQ-015..REQ-025 normally.

Verification
REQ-030 Reset mid-run: q=5 in RUN, reset low between edges -> q=0, busy=0, done=0, tc=0 immediately, before next edge.
REQ-031 One-shot: ld d=3, start, cntdn=1, reload=0 -> q=3,2,1,0 on successive edges; tc=1 only with q=0; done=1; ack -> IDLE, q=0.
REQ-032 Auto-reload: rv=2, reload=1, cntdn=1 -> q=2,1,2,1,...; tc pulses every 2nd edge; busy stays 1, done stays 0.
REQ-033 Stall/ignore: cntdn=0 for 3 cycles at q=4 -> q holds 4; start pulsed in RUN -> no change.
REQ-034 Zero reload: rv=0, start -> DONE next edge, q=0, tc=1 for one clock.
REQ-035 Abort: ld d=7 during RUN with start=1 -> IDLE, q=7, rv=7, busy=0, tc=0.

Source files
------------

// File: rtl/cjb_nbit_cntdn_v.sv
// Loadable n-bit down-counter with one-shot and auto-reload modes.
// It has an IDLE/RUN/DONE control FSM and a registered terminal-count pulse.
module cjb_nbit_cntdn_v #(
  parameter int n = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [n-1:0] d,
  input  logic         ld,
  input  logic         start,
  input  logic         cntdn,
  input  logic         reload,
  input  logic         ack,
  output logic [n-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         tc,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [n-1:0] rv;

  // Control inputs are level-sampled on every rising edge; there is no
  // valid/ready handshake. ld wins over start/ack, and start/ack win over cntdn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      rv    <= '0;
      tc    <= 1'b0;
      state <= IDLE;
    end else begin
      tc <= 1'b0;
      if (ld) begin
        q     <= d;
        rv    <= d;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (rv != '0) begin
                q     <= rv;
                state <= RUN;
              end else begin
                q     <= '0;
                state <= DONE;
                tc    <= 1'b1;
              end
            end
          end
          RUN: begin
            if (cntdn) begin
              // q<=1 is terminal, so RUN can never wrap below zero.
              if (q > n'(1)) begin
                q <= q - n'(1);
              end else if (reload) begin
                q  <= rv;
                tc <= 1'b1;
              end else begin
                q     <= '0;
                state <= DONE;
                tc    <= 1'b1;
              end
            end
          end
          DONE: begin
            q <= '0;
            if (ack) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cjb_nbit_cntdn_v.sv
// Bench for cjb_nbit_cntdn_v: a table of single-cycle vectors drives a scoreboard queue,
// plus hand-written checks for asynchronous reset behaviour.
module tb_cjb_nbit_cntdn_v;
  localparam int N = 8;
  localparam int W = N + 3;

  logic         clock;
  logic         reset;
  logic [N-1:0] d;
  logic         ld, start, cntdn, reload, ack;
  logic [N-1:0] q;
  logic         busy, done, tc;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         ld;
    logic [N-1:0] d;
    logic         start;
    logic         cntdn;
    logic         reload;
    logic         ack;
    logic [N-1:0] eq;
    logic         ebusy;
    logic         edone;
    logic         etc;
  } vec_t;

  vec_t vecs[$];

  cjb_nbit_cntdn_v #(.n(N)) dut (
    .clock(clock), .reset(reset), .d(d), .ld(ld), .start(start),
    .cntdn(cntdn), .reload(reload), .ack(ack), .q(q), .busy(busy),
    .done(done), .tc(tc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got q=%0d busy=%0b done=%0b tc=%0b, expected q=%0d busy=%0b done=%0b tc=%0b",
                  name, act[W-1:3], act[2], act[1], act[0], exp[W-1:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic add(input logic l, input int dv, input logic s, input logic c, input logic r,
                     input logic a, input int eqv, input logic eb, input logic ed, input logic et);
    vec_t v;
    v.ld = l; v.d = N'(dv); v.start = s; v.cntdn = c; v.reload = r; v.ack = a;
    v.eq = N'(eqv); v.ebusy = eb; v.edone = ed; v.etc = et;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    ld = 0; d = '0; start = 0; cntdn = 0; reload = 0; ack = 0;
  endtask

  // driver: apply one vector, push its expectation, then score the DUT after the edge
  task automatic apply(input vec_t v, input int idx);
    logic [W-1:0] e;
    @(negedge clock);
    ld = v.ld; d = v.d; start = v.start; cntdn = v.cntdn; reload = v.reload; ack = v.ack;
    exp_q.push_back({v.eq, v.ebusy, v.edone, v.etc});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL vec%0d: scoreboard queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d", idx), {q, busy, done, tc}, e);
    end
  endtask

  initial begin
    drive_idle();
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {q, busy, done, tc}, '0);
    @(negedge clock);
    reset = 1;

    //   ld d   st cd rl ak   q   b  dn tc
    add(1, 3,   0, 0, 0, 0,   3,  0, 0, 0);  // load
    add(0, 0,   1, 0, 0, 0,   3,  1, 0, 0);  // start one-shot
    add(0, 0,   0, 1, 0, 0,   2,  1, 0, 0);
    add(0, 0,   0, 1, 0, 0,   1,  1, 0, 0);
    add(0, 0,   0, 1, 0, 0,   0,  0, 1, 1);  // terminal count
    add(0, 0,   0, 0, 0, 0,   0,  0, 1, 0);  // tc is one clock only
    add(0, 0,   1, 0, 0, 1,   0,  0, 0, 0);  // ack wins, start ignored in DONE
    add(0, 0,   0, 1, 0, 0,   0,  0, 0, 0);  // cntdn ignored in IDLE
    add(0, 0,   1, 0, 0, 0,   3,  1, 0, 0);  // rv still 3
    add(1, 2,   1, 0, 0, 0,   2,  0, 0, 0);  // ld aborts run
    add(0, 0,   1, 0, 1, 0,   2,  1, 0, 0);
    add(0, 0,   0, 1, 1, 0,   1,  1, 0, 0);  // auto-reload sequence
    add(0, 0,   0, 1, 1, 0,   2,  1, 0, 1);
    add(0, 0,   0, 1, 1, 0,   1,  1, 0, 0);
    add(0, 0,   0, 1, 1, 0,   2,  1, 0, 1);
    add(1, 4,   0, 0, 0, 0,   4,  0, 0, 0);
    add(0, 0,   1, 0, 0, 0,   4,  1, 0, 0);
    add(0, 0,   0, 0, 0, 0,   4,  1, 0, 0);  // stall x3
    add(0, 0,   0, 0, 0, 0,   4,  1, 0, 0);
    add(0, 0,   0, 0, 0, 0,   4,  1, 0, 0);
    add(0, 0,   1, 0, 0, 0,   4,  1, 0, 0);  // start in RUN ignored
    add(0, 0,   0, 0, 0, 1,   4,  1, 0, 0);  // ack in RUN ignored
    add(1, 0,   0, 0, 0, 0,   0,  0, 0, 0);  // zero reload value
    add(0, 0,   1, 0, 0, 0,   0,  0, 1, 1);
    add(0, 0,   0, 0, 0, 0,   0,  0, 1, 0);
    add(0, 0,   0, 0, 0, 1,   0,  0, 0, 0);
    add(1, 7,   0, 0, 0, 0,   7,  0, 0, 0);
    add(0, 0,   1, 0, 0, 0,   7,  1, 0, 0);
    add(0, 0,   0, 1, 0, 0,   6,  1, 0, 0);
    add(1, 7,   1, 1, 0, 0,   7,  0, 0, 0);  // abort with start high
    add(0, 0,   1, 0, 0, 0,   7,  1, 0, 0);  // rv reloaded to 7
    add(1, 255, 0, 0, 0, 0, 255,  0, 0, 0);
    add(0, 0,   1, 0, 0, 0, 255,  1, 0, 0);
    add(0, 0,   0, 1, 0, 0, 254,  1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // asynchronous reset in the middle of a run
    apply('{1'b1, N'(5), 1'b0, 1'b0, 1'b0, 1'b0, N'(5), 1'b0, 1'b0, 1'b0}, 100);
    apply('{1'b0, N'(0), 1'b1, 1'b0, 1'b0, 1'b0, N'(5), 1'b1, 1'b0, 1'b0}, 101);
    @(negedge clock);
    drive_idle();
    reset = 0;
    #1;
    check("async_reset_mid_run", {q, busy, done, tc}, '0);
    @(posedge clock);
    #1;
    check("reset_held", {q, busy, done, tc}, '0);
    @(negedge clock);
    reset = 1;
    // rv was cleared, so the first start after reset is a zero-length run
    apply('{1'b0, N'(0), 1'b1, 1'b0, 1'b0, 1'b0, N'(0), 1'b0, 1'b1, 1'b1}, 102);

    // random stall pattern: the count must only move on enabled cycles
    apply('{1'b1, N'(9), 1'b0, 1'b0, 1'b0, 1'b0, N'(9), 1'b0, 1'b0, 1'b0}, 103);
    apply('{1'b0, N'(0), 1'b1, 1'b0, 1'b0, 1'b0, N'(9), 1'b1, 1'b0, 1'b0}, 104);
    begin
      int cur = 9;
      for (int k = 0; k < 6; k++) begin
        logic en;
        en = 1'($urandom_range(0, 1));
        if (en) cur--;
        apply('{1'b0, N'(0), 1'b0, en, 1'b0, 1'b0, N'(cur), 1'b1, 1'b0, 1'b0}, 105 + k);
      end
    end

    drive_idle();
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
